// File: rtl/alu_pkg.sv
// Shared types and widths for the two-requester ALU arbiter.
package alu_pkg;

    localparam int unsigned DATA_WIDTH  = 16;
    localparam int unsigned ALUOP_WIDTH = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    // One ALU operation as presented by a requester.
    typedef struct packed {
        logic [DATA_WIDTH-1:0]  opA;
        logic [DATA_WIDTH-1:0]  RegData;
        logic [DATA_WIDTH-1:0]  immData;
        logic                   ALUsrc;
        logic [ALUOP_WIDTH-1:0] ALUop;
    } alu_req_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester, response and shared-ALU signals of the ALU arbiter.
interface alu_arbiter_if;
    import alu_pkg::*;

    logic                   req0_valid;
    logic                   req0_ready;
    logic [DATA_WIDTH-1:0]  req0_opA;
    logic [DATA_WIDTH-1:0]  req0_RegData;
    logic [DATA_WIDTH-1:0]  req0_immData;
    logic                   req0_ALUsrc;
    logic [ALUOP_WIDTH-1:0] req0_ALUop;

    logic                   req1_valid;
    logic                   req1_ready;
    logic [DATA_WIDTH-1:0]  req1_opA;
    logic [DATA_WIDTH-1:0]  req1_RegData;
    logic [DATA_WIDTH-1:0]  req1_immData;
    logic                   req1_ALUsrc;
    logic [ALUOP_WIDTH-1:0] req1_ALUop;

    logic                   resp0_valid;
    logic                   resp0_ready;
    logic                   resp1_valid;
    logic                   resp1_ready;
    logic [DATA_WIDTH-1:0]  resp_data;

    logic [DATA_WIDTH-1:0]  alu_opA;
    logic [DATA_WIDTH-1:0]  alu_RegData;
    logic [DATA_WIDTH-1:0]  alu_immData;
    logic                   alu_ALUsrc;
    logic [ALUOP_WIDTH-1:0] alu_ALUop;
    logic [DATA_WIDTH-1:0]  alu_result;

    modport slave (
        input  req0_valid, req0_opA, req0_RegData, req0_immData, req0_ALUsrc, req0_ALUop,
        input  req1_valid, req1_opA, req1_RegData, req1_immData, req1_ALUsrc, req1_ALUop,
        output req0_ready, req1_ready,
        output resp0_valid, resp1_valid, resp_data,
        input  resp0_ready, resp1_ready,
        output alu_opA, alu_RegData, alu_immData, alu_ALUsrc, alu_ALUop,
        input  alu_result
    );

    modport master (
        output req0_valid, req0_opA, req0_RegData, req0_immData, req0_ALUsrc, req0_ALUop,
        output req1_valid, req1_opA, req1_RegData, req1_immData, req1_ALUsrc, req1_ALUop,
        input  req0_ready, req1_ready,
        input  resp0_valid, resp1_valid, resp_data,
        output resp0_ready, resp1_ready,
        input  alu_opA, alu_RegData, alu_immData, alu_ALUsrc, alu_ALUop,
        output alu_result
    );

endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way winner select: sole valid requester wins, pointer breaks ties.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic [1:0] grant_c
);

    always_comb begin
        grant_c = 2'b00;
        case (valid)
            2'b01:   grant_c = 2'b01;
            2'b10:   grant_c = 2'b10;
            2'b11:   grant_c = ptr ? 2'b10 : 2'b01;
            default: grant_c = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters: accept, issue for one
// cycle, then hold the captured result until the granted requester takes it.
module alu_arbiter
    import alu_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave bus
);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] req_valid;
    logic [1:0] grant;
    logic       ptr;
    logic       gnt_idx;
    logic       accept;
    logic       resp_done;

    alu_req_t   req0_f;
    alu_req_t   req1_f;
    alu_req_t   sel_f;
    alu_req_t   lat_f;
    alu_req_t   op_f;
    alu_req_t   alu_q;
    alu_req_t   alu_nxt;

    logic [1:0]            ready_c;
    logic [1:0]            respv_q;
    logic [1:0]            respv_nxt;
    logic [DATA_WIDTH-1:0] resp_data_q;

    assign req_valid = {bus.req1_valid, bus.req0_valid};

    assign req0_f = '{opA: bus.req0_opA, RegData: bus.req0_RegData,
                      immData: bus.req0_immData, ALUsrc: bus.req0_ALUsrc,
                      ALUop: bus.req0_ALUop};
    assign req1_f = '{opA: bus.req1_opA, RegData: bus.req1_RegData,
                      immData: bus.req1_immData, ALUsrc: bus.req1_ALUsrc,
                      ALUop: bus.req1_ALUop};
    assign sel_f  = grant[1] ? req1_f : req0_f;

    rr_arb2 u_rr_arb2 (
        .valid   (req_valid),
        .ptr     (ptr),
        .grant_c (grant)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        resp_done = 1'b0;
        case (state)
            ST_IDLE: begin
                accept = |grant;
                if (accept) state_nxt = ST_ISSUE;
            end
            ST_ISSUE: state_nxt = ST_RESP;
            ST_RESP: begin
                resp_done = gnt_idx ? bus.resp1_ready : bus.resp0_ready;
                if (resp_done) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output logic: ready is combinational, everything else is a next value
    always_comb begin
        ready_c   = 2'b00;
        op_f      = accept ? sel_f : lat_f;
        alu_nxt   = '0;
        respv_nxt = 2'b00;
        if (state == ST_IDLE && !rst) ready_c = grant;
        if (state_nxt == ST_ISSUE) alu_nxt = op_f;
        if (state_nxt == ST_RESP) respv_nxt[gnt_idx] = 1'b1;
    end

    // Latched request, pointer and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_f       <= '0;
            gnt_idx     <= 1'b0;
            ptr         <= 1'b0;
            alu_q       <= '0;
            respv_q     <= 2'b00;
            resp_data_q <= '0;
        end else begin
            if (accept) begin
                lat_f   <= sel_f;
                gnt_idx <= grant[1];
            end
            if (resp_done) ptr <= ~gnt_idx;
            if (state == ST_ISSUE) resp_data_q <= bus.alu_result;
            alu_q   <= alu_nxt;
            respv_q <= respv_nxt;
        end
    end

    assign bus.req0_ready  = ready_c[0];
    assign bus.req1_ready  = ready_c[1];
    assign bus.resp0_valid = respv_q[0];
    assign bus.resp1_valid = respv_q[1];
    assign bus.resp_data   = resp_data_q;
    assign bus.alu_opA     = alu_q.opA;
    assign bus.alu_RegData = alu_q.RegData;
    assign bus.alu_immData = alu_q.immData;
    assign bus.alu_ALUsrc  = alu_q.ALUsrc;
    assign bus.alu_ALUop   = alu_q.ALUop;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a small external ALU model.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_bad;

    alu_arbiter_if bus ();

    alu_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DATA_WIDTH-1:0] alu_model(
        input logic [DATA_WIDTH-1:0]  a,
        input logic [DATA_WIDTH-1:0]  r,
        input logic [DATA_WIDTH-1:0]  i,
        input logic                   src,
        input logic [ALUOP_WIDTH-1:0] op
    );
        logic [DATA_WIDTH-1:0] b;
        b = src ? i : r;
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            default: return '0;
        endcase
    endfunction

    assign bus.alu_result = alu_model(bus.alu_opA, bus.alu_RegData, bus.alu_immData,
                                      bus.alu_ALUsrc, bus.alu_ALUop);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are driven here.
    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    // Let combinational paths settle before sampling.
    task automatic settle();
        #3;
    endtask

    task automatic set_req0(input logic [15:0] a, input logic [15:0] r, input logic [15:0] i,
                            input logic s, input logic [2:0] op);
        bus.req0_opA = a; bus.req0_RegData = r; bus.req0_immData = i;
        bus.req0_ALUsrc = s; bus.req0_ALUop = op;
    endtask

    task automatic set_req1(input logic [15:0] a, input logic [15:0] r, input logic [15:0] i,
                            input logic s, input logic [2:0] op);
        bus.req1_opA = a; bus.req1_RegData = r; bus.req1_immData = i;
        bus.req1_ALUsrc = s; bus.req1_ALUop = op;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rdy0"},  32'(bus.req0_ready),  32'd0);
        chk({tag, "_rdy1"},  32'(bus.req1_ready),  32'd0);
        chk({tag, "_rv0"},   32'(bus.resp0_valid), 32'd0);
        chk({tag, "_rv1"},   32'(bus.resp1_valid), 32'd0);
        chk({tag, "_rdata"}, 32'(bus.resp_data),   32'd0);
        chk({tag, "_aopA"},  32'(bus.alu_opA),     32'd0);
        chk({tag, "_areg"},  32'(bus.alu_RegData), 32'd0);
        chk({tag, "_aimm"},  32'(bus.alu_immData), 32'd0);
        chk({tag, "_asrc"},  32'(bus.alu_ALUsrc),  32'd0);
        chk({tag, "_aop"},   32'(bus.alu_ALUop),   32'd0);
    endtask

    initial begin
        n_chk = 0;
        n_bad = 0;
        rst = 1'b1;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.resp0_ready = 1'b0; bus.resp1_ready = 1'b0;
        set_req0(16'h0, 16'h0, 16'h0, 1'b0, 3'd0);
        set_req1(16'h0, 16'h0, 16'h0, 1'b0, 3'd0);

        edge1(); edge1();
        settle();
        chk_all_zero("reset");
        rst = 1'b0;

        // Response readies while idle must not do anything
        edge1();
        bus.resp0_ready = 1'b1; bus.resp1_ready = 1'b1;
        edge1(); settle();
        chk_all_zero("idle_rr_a");
        edge1(); settle();
        chk_all_zero("idle_rr_b");
        bus.resp0_ready = 1'b0; bus.resp1_ready = 1'b0;

        // req1 alone, register operand: 0x0010 + 0x1234
        edge1();
        set_req1(16'h0010, 16'h1234, 16'h00FF, 1'b0, 3'd0);
        bus.req1_valid = 1'b1;
        settle();
        chk("r1_rdy1", 32'(bus.req1_ready), 32'd1);
        chk("r1_rdy0", 32'(bus.req0_ready), 32'd0);
        chk("r1_idle_areg", 32'(bus.alu_RegData), 32'd0);
        edge1();
        bus.req1_valid = 1'b0;
        settle();
        chk("r1_iss_areg", 32'(bus.alu_RegData), 32'h1234);
        chk("r1_iss_asrc", 32'(bus.alu_ALUsrc),  32'd0);
        chk("r1_iss_aimm", 32'(bus.alu_immData), 32'h00FF);
        chk("r1_iss_rv1",  32'(bus.resp1_valid), 32'd0);
        chk("r1_iss_rdy1", 32'(bus.req1_ready),  32'd0);
        edge1(); settle();
        chk("r1_resp_areg",  32'(bus.alu_RegData), 32'd0);
        chk("r1_resp_rv1",   32'(bus.resp1_valid), 32'd1);
        chk("r1_resp_rv0",   32'(bus.resp0_valid), 32'd0);
        chk("r1_resp_rdata", 32'(bus.resp_data),   32'h1244);
        bus.resp1_ready = 1'b1;
        edge1();
        bus.resp1_ready = 1'b0;
        settle();
        chk("r1_done_rv1", 32'(bus.resp1_valid), 32'd0);

        // req0 alone, immediate add 5 + 3, then a 5-cycle response stall
        set_req0(16'h0005, 16'h0777, 16'h0003, 1'b1, 3'd0);
        bus.req0_valid = 1'b1;
        settle();
        chk("r0_rdy0", 32'(bus.req0_ready), 32'd1);
        edge1();
        bus.req0_valid = 1'b0;
        settle();
        chk("r0_iss_aimm", 32'(bus.alu_immData), 32'h0003);
        chk("r0_iss_aopA", 32'(bus.alu_opA),     32'h0005);
        chk("r0_iss_asrc", 32'(bus.alu_ALUsrc),  32'd1);
        chk("r0_iss_rv0",  32'(bus.resp0_valid), 32'd0);
        edge1();
        set_req0(16'h0100, 16'h0000, 16'h0001, 1'b1, 3'd1);
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            settle();
            chk("stall_rv0",   32'(bus.resp0_valid), 32'd1);
            chk("stall_rdata", 32'(bus.resp_data),   32'h0008);
            chk("stall_rdy0",  32'(bus.req0_ready),  32'd0);
            chk("stall_rdy1",  32'(bus.req1_ready),  32'd0);
            chk("stall_aopA",  32'(bus.alu_opA),     32'd0);
            if (k < 4) edge1();
        end
        bus.resp0_ready = 1'b1;
        edge1();
        bus.resp0_ready = 1'b0;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        settle();
        chk("r0_done_rv0", 32'(bus.resp0_valid), 32'd0);

        // Pointer now favours req1; reset mid-ISSUE must drop it and clear the pointer
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        settle();
        chk("pre_rst_rdy1", 32'(bus.req1_ready), 32'd1);
        chk("pre_rst_rdy0", 32'(bus.req0_ready), 32'd0);
        edge1(); settle();
        chk("pre_rst_aopA", 32'(bus.alu_opA), 32'h0010);
        rst = 1'b1;
        edge1(); settle();
        chk_all_zero("rst_mid1");
        edge1(); settle();
        chk_all_zero("rst_mid2");
        rst = 1'b0;

        // Both valid, responses always consumed: grants 0,1,0,1 every 3 cycles
        bus.resp0_ready = 1'b1; bus.resp1_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            settle();
            chk("alt_rdy0", 32'(bus.req0_ready), (n % 2 == 0) ? 32'd1 : 32'd0);
            chk("alt_rdy1", 32'(bus.req1_ready), (n % 2 == 1) ? 32'd1 : 32'd0);
            edge1(); settle();
            chk("alt_iss_rv", 32'({bus.resp1_valid, bus.resp0_valid}), 32'd0);
            edge1(); settle();
            chk("alt_rv0",   32'(bus.resp0_valid), (n % 2 == 0) ? 32'd1 : 32'd0);
            chk("alt_rv1",   32'(bus.resp1_valid), (n % 2 == 1) ? 32'd1 : 32'd0);
            chk("alt_rdata", 32'(bus.resp_data),   (n % 2 == 0) ? 32'h00FF : 32'h1244);
            edge1();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
